icache_fetch_responder: RTL

- Responder end of the IF→icache fetch interface. It accepts one fetch request per handshake: PC, valid, read/write flag and delay-slot flag.
- It returns a 4-word (16-byte) fetch group to ID, with per-slot valid bits.
- Hits are served from a single-line buffer. Misses are refilled through a 4-beat line read on the memory port.
- It sits between the IF stage and ID; it handles EX branch-mispredict and CP0 exception flushes.

---
 rtl/icache_fetch_responder_pkg.sv | 20 ++
 rtl/icache_fetch_responder_fetch_slot_mask.sv | 19 +
 rtl/icache_fetch_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/icache_fetch_responder_pkg.sv
// Shared definitions for the fetch responder: FSM encoding, line geometry and slot masks.
package icache_fetch_responder_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StRefill = 2'd2
  } state_e;

  localparam int unsigned LineWords = 4;
  localparam int unsigned OffLsb    = 2;
  localparam int unsigned OffMsb    = 3;
  localparam int unsigned TagLsb    = 4;

  localparam logic [1:0] BeatLast = 2'(LineWords - 1);

  // Sequential-fetch masks indexed by line offset; entry 0 is the whole line.
  localparam logic [3:0][3:0] SlotMaskSeq = {4'b1000, 4'b1100, 4'b1110, 4'b1111};

endpackage

// File: rtl/icache_fetch_responder_fetch_slot_mask.sv
// Maps a word offset within the line and the delay-slot flag to per-slot valid bits.
module icache_fetch_responder_fetch_slot_mask
  import icache_fetch_responder_pkg::*;
(
  input  logic [1:0] off_i,
  input  logic       delot_en_i,
  output logic [3:0] mask_o
);

  always_comb begin
    mask_o = '0;
    if (delot_en_i) begin
      mask_o[off_i] = 1'b1;
    end else begin
      mask_o = SlotMaskSeq[off_i];
    end
  end

endmodule

// File: rtl/icache_fetch_responder.sv
// Icache responder for IF fetch requests: single-line buffer, 4-beat refill, flush-aware response.
module icache_fetch_responder
  import icache_fetch_responder_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INSN_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            if_icache_pc,
  input  logic                         if_valid_ns,
  input  logic                         if_rw,
  input  logic [3:0]                   if_rwen,
  input  logic                         if_icache_delot_en,
  output logic                         icache_allin,
  input  logic                         ex_bp_error,
  input  logic                         exc_flush_all,
  output logic                         icache_valid_ns,
  output logic [ADDR_W-1:0]            icache_pc,
  output logic [LINE_WORDS*INSN_W-1:0] icache_insn,
  output logic [3:0]                   icache_insn_vld,
  output logic                         icache_delot_en,
  input  logic                         id_allin,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_req_ack,
  input  logic                         mem_rvalid,
  input  logic [INSN_W-1:0]            mem_rdata
);

  localparam int unsigned TagW = ADDR_W - TagLsb;

  state_e                             state_q, state_d;
  logic                               drop_q, drop_d;
  logic [1:0]                         beat_q, beat_d;
  logic                               buf_vld_q, buf_vld_d;
  logic [TagW-1:0]                    tag_q, tag_d;
  logic [LINE_WORDS-1:0][INSN_W-1:0]  buf_q, buf_d;
  logic [ADDR_W-1:0]                  req_pc_q, req_pc_d;
  logic                               req_delot_q, req_delot_d;
  logic                               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]                  mem_addr_q, mem_addr_d;
  logic                               rsp_vld_q, rsp_vld_d;
  logic [ADDR_W-1:0]                  rsp_pc_q, rsp_pc_d;
  logic [LINE_WORDS*INSN_W-1:0]       rsp_insn_q, rsp_insn_d;
  logic [3:0]                         rsp_slot_q, rsp_slot_d;
  logic                               rsp_delot_q, rsp_delot_d;

  logic                         flush, accept, hit, load;
  logic [ADDR_W-1:0]            load_pc;
  logic                         load_delot;
  logic [LINE_WORDS*INSN_W-1:0] load_insn;
  logic [3:0]                   slot_mask;

  // Write enables only matter on the data side; fetches are read-only.
  logic unused_rwen;
  assign unused_rwen = ^if_rwen;

  assign flush        = ex_bp_error | exc_flush_all;
  assign icache_allin = (state_q == StIdle) & ~flush & (~rsp_vld_q | id_allin);
  assign accept       = if_valid_ns & ~if_rw & icache_allin;
  assign hit          = buf_vld_q & (tag_q == if_icache_pc[ADDR_W-1:TagLsb]);

  icache_fetch_responder_fetch_slot_mask u_slot_mask (
    .off_i      (load_pc[OffMsb:OffLsb]),
    .delot_en_i (load_delot),
    .mask_o     (slot_mask)
  );

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    beat_d      = beat_q;
    buf_vld_d   = buf_vld_q;
    tag_d       = tag_q;
    buf_d       = buf_q;
    req_pc_d    = req_pc_q;
    req_delot_d = req_delot_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    load        = 1'b0;
    load_pc     = if_icache_pc;
    load_delot  = if_icache_delot_en;
    load_insn   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (hit) begin
            load = 1'b1;
          end else begin
            req_pc_d    = if_icache_pc;
            req_delot_d = if_icache_delot_en;
            mem_addr_d  = {if_icache_pc[ADDR_W-1:TagLsb], {TagLsb{1'b0}}};
            mem_req_d   = 1'b1;
            buf_vld_d   = 1'b0;
            drop_d      = 1'b0;
            state_d     = StReq;
          end
        end
      end
      StReq: begin
        if (flush) drop_d = 1'b1;
        if (mem_req_ack) begin
          mem_req_d = 1'b0;
          beat_d    = '0;
          state_d   = StRefill;
        end
      end
      StRefill: begin
        if (flush) drop_d = 1'b1;
        if (mem_rvalid) begin
          buf_d[beat_q] = mem_rdata;
          beat_d        = beat_q + 2'd1;
          if (beat_q == BeatLast) begin
            // Line is installed even when dropped so a re-fetch after the flush hits.
            tag_d      = req_pc_q[ADDR_W-1:TagLsb];
            buf_vld_d  = 1'b1;
            load       = ~drop_q;
            load_pc    = req_pc_q;
            load_delot = req_delot_q;
            load_insn  = buf_d;
            drop_d     = 1'b0;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rsp_vld_d   = rsp_vld_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_insn_d  = rsp_insn_q;
    rsp_slot_d  = rsp_slot_q;
    rsp_delot_d = rsp_delot_q;
    if (flush || (!load && rsp_vld_q && id_allin)) begin
      rsp_vld_d   = 1'b0;
      rsp_pc_d    = '0;
      rsp_insn_d  = '0;
      rsp_slot_d  = '0;
      rsp_delot_d = 1'b0;
    end else if (load) begin
      rsp_vld_d   = 1'b1;
      rsp_pc_d    = load_pc;
      rsp_insn_d  = load_insn;
      rsp_slot_d  = slot_mask;
      rsp_delot_d = load_delot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      drop_q      <= 1'b0;
      beat_q      <= '0;
      buf_vld_q   <= 1'b0;
      tag_q       <= '0;
      buf_q       <= '0;
      req_pc_q    <= '0;
      req_delot_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_pc_q    <= '0;
      rsp_insn_q  <= '0;
      rsp_slot_q  <= '0;
      rsp_delot_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      beat_q      <= beat_d;
      buf_vld_q   <= buf_vld_d;
      tag_q       <= tag_d;
      buf_q       <= buf_d;
      req_pc_q    <= req_pc_d;
      req_delot_q <= req_delot_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_insn_q  <= rsp_insn_d;
      rsp_slot_q  <= rsp_slot_d;
      rsp_delot_q <= rsp_delot_d;
    end
  end

  assign icache_valid_ns = rsp_vld_q;
  assign icache_pc       = rsp_pc_q;
  assign icache_insn     = rsp_insn_q;
  assign icache_insn_vld = rsp_slot_q;
  assign icache_delot_en = rsp_delot_q;
  assign mem_req         = mem_req_q;
  assign mem_addr        = mem_addr_q;

endmodule
